// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_pkg;

  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 32;
  // Wait-state counter is wide enough for 0..15 inserted cycles.
  localparam int CNT_WIDTH      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/mem_array.sv
// Single-port word store: one address, one write port, combinational read.
// The parent registers the read word, so the access completes on one edge.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Storage is never reset; contents survive a reset of the responder.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/memory_unit.sv
// Wait-state memory responder for the MAR/MDR bus: latches a request,
// counts WAIT_CYCLES wait states, performs the access and pulses Done.
module memory_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] MAR_addr,
  input  logic [DATA_WIDTH-1:0] MDR_data,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  Done,
  output logic                  Busy
);

  localparam logic [CNT_WIDTH-1:0] WAIT_INIT = CNT_WIDTH'(WAIT_CYCLES);

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  op_e                     op_q, op_d;
  logic [DATA_WIDTH-1:0]   mdatain_q, mdatain_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem_array (
    .clock   (clock),
    .wr_en   (mem_we),
    .addr    (mem_addr),
    .wr_data (mem_wdata),
    .rd_data (mem_rdata)
  );

  // Next-state logic: request latch, wait countdown, access and the
  // single RAM port mux (preload in IDLE, latched access in BUSY).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    op_d      = op_q;
    mdatain_d = mdatain_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = data_q;

    case (state_q)
      ST_IDLE: begin
        // Preload writes this edge; a coinciding request reads it later.
        if (load_en) begin
          mem_we    = 1'b1;
          mem_addr  = load_addr;
          mem_wdata = load_data;
        end
        if (Read || Write) begin
          addr_d  = MAR_addr;
          data_d  = MDR_data;
          op_d    = Read ? OP_READ : OP_WRITE;
          cnt_d   = WAIT_INIT;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Request levels are ignored here; the latched access always runs.
        if (cnt_q == '0) begin
          if (op_q == OP_READ) begin
            mdatain_d = mem_rdata;
          end else begin
            mem_we = 1'b1;
          end
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset aborts any pending access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      op_q      <= OP_READ;
      mdatain_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      op_q      <= op_d;
      mdatain_q <= mdatain_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign Mdatain = mdatain_q;
  assign Done    = done_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: vector table, hand-written corner
// sequences, randomized traffic against an array-based reference model.
module tb_memory_unit;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int W1 = 1;
  localparam int W3 = 3;

  logic          clock;
  // main instance, WAIT_CYCLES = 1
  logic          reset_n;
  logic          Read, Write, load_en;
  logic [AW-1:0] MAR_addr, load_addr;
  logic [DW-1:0] MDR_data, load_data;
  logic [DW-1:0] Mdatain;
  logic          Done, Busy;
  // second instance, WAIT_CYCLES = 3
  logic          r3_reset_n;
  logic          r3_read, r3_write, r3_load_en;
  logic [AW-1:0] r3_addr, r3_load_addr;
  logic [DW-1:0] r3_wdata, r3_load_data;
  logic [DW-1:0] r3_mdatain;
  logic          r3_done, r3_busy;

  memory_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(W1)) u_dut (
    .clock(clock), .reset_n(reset_n), .Read(Read), .Write(Write),
    .MAR_addr(MAR_addr), .MDR_data(MDR_data), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data),
    .Mdatain(Mdatain), .Done(Done), .Busy(Busy));

  memory_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(W3)) u_dut3 (
    .clock(clock), .reset_n(r3_reset_n), .Read(r3_read), .Write(r3_write),
    .MAR_addr(r3_addr), .MDR_data(r3_wdata), .load_en(r3_load_en),
    .load_addr(r3_load_addr), .load_data(r3_load_data),
    .Mdatain(r3_mdatain), .Done(r3_done), .Busy(r3_busy));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // reference model: word array plus the last read word
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic [DW-1:0] model_md;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_md;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    model_mem[a] = d;
  endtask

  // Count edges after the sampling edge until Done; Busy must stay high.
  task automatic wait_done(output int lat, output bit seen, output int busy_gap);
    lat = 0; seen = 1'b0; busy_gap = 0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (Done) seen = 1'b1;
      else if (!Busy) busy_gap++;
    end
  endtask

  // One complete access starting from IDLE; any pending load_en is
  // sampled on the same edge as the request.
  task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit drop_early,
                           input logic [DW-1:0] exp_md, input string tag);
    int lat; bit seen; int gap;
    Read = rd; Write = wr; MAR_addr = a; MDR_data = d;
    tick();
    load_en = 1'b0;
    chk({tag, " busy_after_sample"}, {31'd0, Busy}, 32'd1);
    if (drop_early) begin Read = 1'b0; Write = 1'b0; end
    wait_done(lat, seen, gap);
    if (!seen) begin
      tot_cnt++;
      $display("FAIL %s done_timeout: no Done within %0d cycles", tag, lat);
    end else begin
      chk({tag, " latency"}, 32'(lat), 32'(W1 + 1));
    end
    chk({tag, " busy_gap"}, 32'(gap), 32'd0);
    chk({tag, " busy_in_done"}, {31'd0, Busy}, 32'd1);
    chk({tag, " mdatain"}, Mdatain, exp_md);
    Read = 1'b0; Write = 1'b0;
    tick();
    chk({tag, " done_cleared"}, {31'd0, Done}, 32'd0);
    chk({tag, " idle_busy"}, {31'd0, Busy}, 32'd0);
    $display("txn %-10s rd=%0d wr=%0d addr=0x%03h wdata=0x%08h mdatain=0x%08h", tag, rd, wr, a, d, Mdatain);
  endtask

  // Model-driven access: expectation comes from the reference array.
  task automatic model_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input bit drop_early, input string tag);
    logic [DW-1:0] exp;
    exp = rd ? model_mem[a] : model_md;
    if (!rd && wr) model_mem[a] = d;
    model_md = exp;
    do_access(rd, wr, a, d, drop_early, exp, tag);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd_word;
    int op;

    reset_n = 1'b0; Read = 0; Write = 0; load_en = 0;
    MAR_addr = '0; MDR_data = '0; load_addr = '0; load_data = '0;
    r3_reset_n = 1'b0; r3_read = 0; r3_write = 0; r3_load_en = 0;
    r3_addr = '0; r3_wdata = '0; r3_load_addr = '0; r3_load_data = '0;
    model_md = '0;

    repeat (2) @(posedge clock);
    #1;
    chk("reset_mdatain", Mdatain, 32'd0);
    chk("reset_done", {31'd0, Done}, 32'd0);
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1; r3_reset_n = 1'b1;
    tick();

    // preload the words the vector table relies on
    preload(9'h012, 32'h28918000);
    preload(9'h0A3, 32'hAAAA0001);
    preload(9'h0A4, 32'h0BADF00D);
    preload(9'h005, 32'h00000011);
    preload(9'h020, 32'h20202020);
    preload(9'h030, 32'h30303030);
    preload(9'h031, 32'h31313131);

    vecs[0] = '{1'b1, 1'b0, 9'h012, 32'h0,        32'h28918000};
    vecs[1] = '{1'b0, 1'b1, 9'h0A3, 32'h00000014, 32'h28918000};
    vecs[2] = '{1'b1, 1'b0, 9'h0A3, 32'h0,        32'h00000014};
    vecs[3] = '{1'b1, 1'b0, 9'h0A4, 32'h0,        32'h0BADF00D};
    vecs[4] = '{1'b1, 1'b1, 9'h005, 32'hDEADBEEF, 32'h00000011};
    vecs[5] = '{1'b1, 1'b0, 9'h005, 32'h0,        32'h00000011};

    for (int i = 0; i < 6; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0,
                vecs[i].exp_md, $sformatf("vec%0d", i));
      if (!vecs[i].rd && vecs[i].wr) model_mem[vecs[i].addr] = vecs[i].wdata;
      model_md = vecs[i].exp_md;
    end

    // Read dropped right after sampling still completes
    do_access(1'b1, 1'b0, 9'h020, 32'h0, 1'b1, 32'h20202020, "drop_rd");
    model_md = 32'h20202020;

    // Read held one cycle past Done starts a second access at N+3+W
    Read = 1'b1; MAR_addr = 9'h012;
    tick();
    for (int i = 0; i < W1 + 1; i++) tick();
    chk("hold first_done", {31'd0, Done}, 32'd1);
    chk("hold first_md", Mdatain, 32'h28918000);
    tick();
    chk("hold turnaround_busy", {31'd0, Busy}, 32'd0);
    chk("hold turnaround_done", {31'd0, Done}, 32'd0);
    MAR_addr = 9'h0A4;
    tick();
    chk("hold restart_busy", {31'd0, Busy}, 32'd1);
    Read = 1'b0;
    for (int i = 0; i < W1 + 1; i++) tick();
    chk("hold second_done", {31'd0, Done}, 32'd1);
    chk("hold second_md", Mdatain, 32'h0BADF00D);
    model_md = 32'h0BADF00D;
    tick();
    $display("txn hold       two back-to-back reads from one held Read level");

    // Preload while BUSY is ignored
    Read = 1'b1; MAR_addr = 9'h030;
    tick();
    Read = 1'b0;
    load_en = 1'b1; load_addr = 9'h031; load_data = 32'hFFFFFFFF;
    tick();
    load_en = 1'b0;
    begin
      int gap;
      wait_done(lat, seen, gap);
    end
    chk("busy_load first_md", Mdatain, 32'h30303030);
    tick();
    model_md = 32'h30303030;
    model_access(1'b1, 1'b0, 9'h031, 32'h0, 1'b0, "busy_load");

    // Preload coinciding with a read of the same address in IDLE
    load_en = 1'b1; load_addr = 9'h040; load_data = 32'h44444444;
    model_mem[9'h040] = 32'h44444444;
    model_access(1'b1, 1'b0, 9'h040, 32'h0, 1'b0, "load_coinc");

    // Reset in the second BUSY cycle of a WAIT_CYCLES=3 write
    r3_load_en = 1'b1; r3_load_addr = 9'h010; r3_load_data = 32'h22;
    tick();
    r3_load_en = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      r3_read = 1'b1; r3_addr = 9'h010;
      tick();
      r3_read = 1'b0;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 40) begin
        tick(); lat++;
        if (r3_done) seen = 1'b1;
      end
      chk($sformatf("rst3 read%0d_latency", pass), 32'(lat), 32'(W3 + 1));
      chk($sformatf("rst3 read%0d_md", pass), r3_mdatain, 32'h22);
      tick();
      $display("txn rst3_rd%0d   addr=0x010 mdatain=0x%08h", pass, r3_mdatain);
      if (pass == 0) begin
        r3_write = 1'b1; r3_addr = 9'h010; r3_wdata = 32'h55;
        tick();
        r3_write = 1'b0;
        tick();
        #2 r3_reset_n = 1'b0;
        #1;
        chk("rst3 mdatain_cleared", r3_mdatain, 32'd0);
        chk("rst3 busy_cleared", {31'd0, r3_busy}, 32'd0);
        chk("rst3 done_cleared", {31'd0, r3_done}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        r3_reset_n = 1'b1;
        tick();
        $display("txn rst3_abort write 0x55 to 0x010 aborted by reset");
      end
    end

    // Randomized traffic over a preloaded pool against the model
    for (int i = 0; i < 32; i++) preload(AW'(9'h100 + i), $urandom);
    for (int i = 0; i < 60; i++) begin
      ra = AW'(9'h100 + $urandom_range(0, 31));
      rd_word = $urandom;
      op = $urandom_range(0, 3);
      case (op)
        0: model_access(1'b1, 1'b0, ra, rd_word, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        1: model_access(1'b0, 1'b1, ra, rd_word, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        2: model_access(1'b1, 1'b1, ra, rd_word, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        default: begin
          load_en = 1'b1; load_addr = ra; load_data = rd_word;
          model_mem[ra] = rd_word;
          model_access(1'b1, 1'b0, ra, 32'h0, 1'b0, $sformatf("rnd%0d", i));
        end
      endcase
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
